fft_frame_ctrl: RTL and testbench

Frame sequencer for the FIR -> sample FIFO -> FFT path. It aligns each FFT frame to a chirp start from the synthesizer, discards settling samples, and gates exactly FFT_N filtered samples into the FIR/FFT FIFO. Once the FIFO reports full, it drains the FIFO into the FFT with the correct one-cycle read latency. It aborts frames on early ramps, drops frames when the USB path is not ready, and keeps drop and error counters for the host.

---
 rtl/fft_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FIR -> sample FIFO -> FFT path: aligns frames to chirp
// starts, skips settling samples, fills the FIFO with FFT_N samples and drains it into the FFT.
module fft_frame_ctrl #(
  parameter int FFT_N           = 1024,
  parameter int N_WIDTH         = $clog2(FFT_N),
  parameter int HOLDOFF_SAMPLES = 16,
  parameter int FULL_TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        ramp_start_i,
  input  logic        sample_valid_i,
  input  logic        tx_ready_i,
  input  logic        fifo_full_i,
  output logic        fifo_wren_o,
  output logic        fifo_rden_o,
  output logic        fifo_clr_o,
  output logic        fft_en_o,
  output logic        frame_start_o,
  output logic        busy_o,
  output logic [15:0] frame_ctr_o,
  output logic [7:0]  drop_ctr_o,
  output logic [7:0]  err_ctr_o
);

  typedef enum logic [2:0] {IDLE, HOLDOFF, CAPTURE, WAIT_FULL, DRAIN} state_t;

  localparam int HW = (HOLDOFF_SAMPLES > 1) ? $clog2(HOLDOFF_SAMPLES) : 1;
  localparam int TW = (FULL_TIMEOUT > 1) ? $clog2(FULL_TIMEOUT) : 1;
  localparam logic [HW-1:0]      HOLD_LAST = HW'((HOLDOFF_SAMPLES > 0) ? HOLDOFF_SAMPLES - 1 : 0);
  localparam logic [TW-1:0]      T_LAST    = TW'(FULL_TIMEOUT - 1);
  localparam logic [N_WIDTH-1:0] WR_LAST   = N_WIDTH'(FFT_N - 1);
  localparam logic [N_WIDTH:0]   RD_LAST   = (N_WIDTH+1)'(FFT_N - 1);
  localparam logic [N_WIDTH:0]   RD_END    = (N_WIDTH+1)'(FFT_N);
  localparam state_t FIRST = (HOLDOFF_SAMPLES == 0) ? CAPTURE : HOLDOFF;

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [N_WIDTH-1:0]   wr_q, wr_d;
  logic [TW-1:0]        wt_q, wt_d;
  logic [N_WIDTH:0]     rd_q, rd_d;
  logic                 rden_q, rden_d, clr_q, clr_d, fft_q, fs_q, busy_q;
  logic [15:0]          frame_q;
  logic [7:0]           drop_q, err_q;
  logic                 drop_inc, err_inc, frame_inc, start_ok, abort;

  assign start_ok    = enable_i & tx_ready_i;
  // A ramp in the same cycle as a sample aborts the frame, so that sample is never written.
  assign fifo_wren_o = sample_valid_i & (state_q == CAPTURE) & ~ramp_start_i;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wr_d      = wr_q;
    wt_d      = wt_q;
    rd_d      = rd_q;
    rden_d    = 1'b0;
    clr_d     = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    frame_inc = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: if (ramp_start_i && enable_i) begin
        if (tx_ready_i) begin
          state_d = FIRST;
          hold_d  = '0;
          wr_d    = '0;
        end else begin
          drop_inc = 1'b1;
        end
      end
      HOLDOFF: begin
        if (ramp_start_i) abort = 1'b1;
        else if (sample_valid_i) begin
          if (hold_q == HOLD_LAST) begin
            state_d = CAPTURE;
            wr_d    = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (ramp_start_i) abort = 1'b1;
        else if (sample_valid_i) begin
          if (wr_q == WR_LAST) begin
            state_d = WAIT_FULL;
            wr_d    = '0;
            wt_d    = '0;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end
      WAIT_FULL: begin
        drop_inc = ramp_start_i;
        if (fifo_full_i) begin
          state_d = DRAIN;
          rden_d  = 1'b1;
          rd_d    = '0;
        end else if (wt_q == T_LAST) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          err_inc = 1'b1;
        end else begin
          wt_d = wt_q + 1'b1;
        end
      end
      DRAIN: begin
        drop_inc = ramp_start_i;
        rd_d     = rd_q + 1'b1;
        rden_d   = (rd_q < RD_LAST);
        // fft_en lags rden by one, so the last FFT beat lands on rd_q == FFT_N.
        if (rd_q == RD_END) begin
          state_d   = IDLE;
          frame_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      clr_d    = 1'b1;
      drop_inc = 1'b1;
      hold_d   = '0;
      wr_d     = '0;
      state_d  = start_ok ? FIRST : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      wr_q    <= '0;
      wt_q    <= '0;
      rd_q    <= '0;
      rden_q  <= 1'b0;
      clr_q   <= 1'b0;
      fft_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      wt_q    <= wt_d;
      rd_q    <= rd_d;
      rden_q  <= rden_d;
      clr_q   <= clr_d;
      fft_q   <= rden_q;
      fs_q    <= rden_q && (state_q == DRAIN) && (rd_q == '0);
      busy_q  <= (state_d != IDLE);
      if (frame_inc) frame_q <= frame_q + 16'd1;
      if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign fifo_rden_o   = rden_q;
  assign fifo_clr_o    = clr_q;
  assign fft_en_o      = fft_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;
  assign frame_ctr_o   = frame_q;
  assign drop_ctr_o    = drop_q;
  assign err_ctr_o     = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with FFT_N=16, HOLDOFF_SAMPLES=4, FULL_TIMEOUT=8.
module tb_fft_frame_ctrl;
  localparam int N   = 16;
  localparam int HO  = 4;
  localparam int TO  = 8;
  localparam int GAP = 20;

  logic clk_i = 1'b0, rst = 1'b1;
  logic enable_i = 1'b0, ramp_start_i = 1'b0, sample_valid_i = 1'b0;
  logic tx_ready_i = 1'b0, fifo_full_i = 1'b0;
  logic fifo_wren_o, fifo_rden_o, fifo_clr_o, fft_en_o, frame_start_o, busy_o;
  logic [15:0] frame_ctr_o;
  logic [7:0]  drop_ctr_o, err_ctr_o;

  fft_frame_ctrl #(.FFT_N(N), .HOLDOFF_SAMPLES(HO), .FULL_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst(rst), .enable_i(enable_i), .ramp_start_i(ramp_start_i),
    .sample_valid_i(sample_valid_i), .tx_ready_i(tx_ready_i), .fifo_full_i(fifo_full_i),
    .fifo_wren_o(fifo_wren_o), .fifo_rden_o(fifo_rden_o), .fifo_clr_o(fifo_clr_o),
    .fft_en_o(fft_en_o), .frame_start_o(frame_start_o), .busy_o(busy_o),
    .frame_ctr_o(frame_ctr_o), .drop_ctr_o(drop_ctr_o), .err_ctr_o(err_ctr_o));

  always #5 clk_i = ~clk_i;

  int nvec = 0, nmis = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, n_fft = 0, n_fs = 0, n_clr = 0, n_busy = 0, lag_err = 0;
  int last_wr_cyc = 0, clr_cyc = 0;
  logic prev_rd = 1'b0;

  // Event counters sampled mid-cycle; tests compare deltas against hand-computed counts.
  always @(negedge clk_i) begin
    cyc++;
    if (fifo_wren_o) begin n_wr++; last_wr_cyc = cyc; end
    if (fifo_rden_o) n_rd++;
    if (fft_en_o) n_fft++;
    if (frame_start_o) n_fs++;
    if (fifo_clr_o) begin n_clr++; clr_cyc = cyc; end
    if (busy_o) n_busy++;
    if (!rst && (fft_en_o != prev_rd || (frame_start_o && !fft_en_o))) lag_err++;
    prev_rd = fifo_rden_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic ramp();
    ramp_start_i = 1'b1; tick(1); ramp_start_i = 1'b0;
  endtask

  task automatic valids(input int n);
    repeat (n) begin
      tick(GAP - 1);
      sample_valid_i = 1'b1; tick(1); sample_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy_o && k < limit) begin tick(1); k++; end
    if (busy_o) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_rden(input int limit);
    int k = 0;
    while (!fifo_rden_o && k < limit) begin tick(1); k++; end
    if (!fifo_rden_o) chk("rden_timeout", 0, 1);
  endtask

  // Full frame: holdoff + N writes, full raised 3 clk after the last write, drain.
  task automatic frame(input bit ramp_in_drain);
    enable_i = 1'b1; tx_ready_i = 1'b1;
    ramp();
    valids(HO + N);
    tick(2); fifo_full_i = 1'b1;
    if (ramp_in_drain) begin
      wait_rden(20); tick(3); ramp();
    end
    wait_idle(100);
    fifo_full_i = 1'b0;
    tick(2);
  endtask

  int w0, r0, f0, s0, c0, b0;
  task automatic snap();
    w0 = n_wr; r0 = n_rd; f0 = n_fft; s0 = n_fs; c0 = n_clr; b0 = n_busy;
  endtask

  initial begin
    tick(3);
    chk("rst_frame", frame_ctr_o, 0);
    chk("rst_drop", drop_ctr_o, 0);
    chk("rst_err", err_ctr_o, 0);
    chk("rst_outs", {fifo_wren_o, fifo_rden_o, fifo_clr_o, fft_en_o, frame_start_o, busy_o}, 0);
    rst = 1'b0; tick(2);

    // normal frame
    snap();
    enable_i = 1'b1; tx_ready_i = 1'b1;
    ramp();
    chk("busy_after_ramp", busy_o, 1);
    valids(HO + N);
    tick(2); fifo_full_i = 1'b1;
    wait_idle(100); fifo_full_i = 1'b0; tick(2);
    chk("n_wren", n_wr - w0, N);
    chk("n_rden", n_rd - r0, N);
    chk("n_fft", n_fft - f0, N);
    chk("n_fstart", n_fs - s0, 1);
    chk("frame1", frame_ctr_o, 1);
    chk("lag", lag_err, 0);

    // abort after 7 writes; ramp coincides with a sample that must not be written
    snap();
    ramp();
    valids(HO + 7);
    tick(GAP - 1);
    sample_valid_i = 1'b1; ramp_start_i = 1'b1; tick(1);
    sample_valid_i = 1'b0; ramp_start_i = 1'b0;
    chk("abort_clr", fifo_clr_o, 1);
    tick(1);
    chk("abort_clr_width", fifo_clr_o, 0);
    chk("abort_drop", drop_ctr_o, 1);
    valids(HO + N);
    tick(2); fifo_full_i = 1'b1;
    wait_idle(100); fifo_full_i = 1'b0; tick(2);
    chk("abort_wren", n_wr - w0, 7 + N);
    chk("abort_nclr", n_clr - c0, 1);
    chk("frame2", frame_ctr_o, 2);

    // tx not ready; enable low
    snap();
    tx_ready_i = 1'b0; ramp(); valids(3); tick(3);
    chk("txr_busy", n_busy - b0, 0);
    chk("txr_wren", n_wr - w0, 0);
    chk("txr_drop", drop_ctr_o, 2);
    enable_i = 1'b0; tx_ready_i = 1'b1; ramp(); tick(3);
    chk("en_low_busy", busy_o, 0);
    chk("en_low_drop", drop_ctr_o, 2);
    frame(1'b0);
    chk("frame3", frame_ctr_o, 3);

    // fill timeout
    snap();
    ramp(); valids(HO + N);
    wait_idle(100); tick(2);
    chk("to_err", err_ctr_o, 1);
    chk("to_nclr", n_clr - c0, 1);
    chk("to_clr_dly", clr_cyc - last_wr_cyc, 1 + TO);
    chk("to_rden", n_rd - r0, 0);
    chk("to_frame", frame_ctr_o, 3);

    // ramp during drain
    snap();
    frame(1'b1);
    chk("drn_drop", drop_ctr_o, 3);
    chk("drn_fft", n_fft - f0, N);
    chk("drn_frame", frame_ctr_o, 4);
    chk("drn_idle", busy_o, 0);
    chk("lag2", lag_err, 0);

    // drop counter saturation
    enable_i = 1'b1; tx_ready_i = 1'b0;
    ramp_start_i = 1'b1; tick(300); ramp_start_i = 1'b0; tick(1);
    chk("drop_sat", drop_ctr_o, 255);

    // reset mid-capture
    tx_ready_i = 1'b1;
    ramp(); valids(HO + 5);
    chk("pre_rst_busy", busy_o, 1);
    snap();
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst2_ctrs", {frame_ctr_o, drop_ctr_o, err_ctr_o}, 0);
    chk("rst2_outs", {fifo_wren_o, fifo_rden_o, fifo_clr_o, fft_en_o, frame_start_o, busy_o}, 0);
    tick(3);
    chk("rst2_noclr", n_clr - c0, 0);
    snap();
    frame(1'b0);
    chk("rst2_wren", n_wr - w0, N);
    chk("rst2_frame", frame_ctr_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
